regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 30 +++
 rtl/regfile_sb.sv | 125 ++++++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Register-file bus: write-back ports, read ports, issue/scoreboard and status.
// master drives write-back, read indices, issue and flush; slave returns read data,
// busy flags and init_done.
interface regfile_sb_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2
);
    logic [NWR-1:0]        wb_wen;
    logic [NWR*ADDR_W-1:0] wb_rd;
    logic [NWR*WIDTH-1:0]  wb_data;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*WIDTH-1:0]  rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  iss_valid;
    logic [ADDR_W-1:0]     iss_rd;
    logic                  flush;
    logic                  init_done;

    modport master (
        output wb_wen, wb_rd, wb_data, rd_addr, iss_valid, iss_rd, flush,
        input  rd_data, rd_busy, init_done
    );

    modport slave (
        input  wb_wen, wb_rd, wb_data, rd_addr, iss_valid, iss_rd, flush,
        output rd_data, rd_busy, init_done
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-ported register file with a pending-write scoreboard.
// Register 0 reads as zero. After reset an INIT sweep clears one register per cycle;
// reads return 0 and writes/issues are ignored until the sweep completes.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_sb #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2
) (
    input logic          clk,
    input logic          rst,
    regfile_sb_if.slave  bus
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              init_done;
    logic [NWR-1:0]    wr_ok;
    logic [ADDR_W-1:0] ra;

    assign init_done     = (state_q == StRun);
    assign bus.init_done = init_done;

    // Qualify each write port: enabled, non-zero target, initialisation finished
    always_comb begin
        wr_ok = '0;
        for (int i = 0; i < NWR; i++) begin
            wr_ok[i] = bus.wb_wen[i] && (bus.wb_rd[i*ADDR_W +: ADDR_W] != '0) && init_done;
        end
    end

    // FSM next state: sweep cnt through every index, then run
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StInit: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    // Scoreboard next state: clears first so a same-index set wins; flush overrides all
    always_comb begin
        busy_d = busy_q;
        if (state_q == StRun) begin
            for (int i = 0; i < NWR; i++) begin
                if (bus.wb_wen[i]) begin
                    busy_d[bus.wb_rd[i*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (bus.iss_valid && (bus.iss_rd != '0)) begin
                busy_d[bus.iss_rd] = 1'b1;
            end
        end
        if (bus.flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array: no reset, cleared by the INIT sweep; later ports override earlier ones
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_ok[i]) begin
                    mem[bus.wb_rd[i*ADDR_W +: ADDR_W]] <= bus.wb_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Combinational read ports with scoreboard lookup
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra          = '0;
        for (int j = 0; j < NRD; j++) begin
            ra = bus.rd_addr[j*ADDR_W +: ADDR_W];
            if (init_done && (ra != '0)) begin
                bus.rd_data[j*WIDTH +: WIDTH] = mem[ra];
            end
            bus.rd_busy[j] = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            // Ascending scan so the highest-numbered matching write is forwarded
            for (int i = 0; i < NWR; i++) begin
                if (wr_ok[i] && (bus.wb_rd[i*ADDR_W +: ADDR_W] == ra)) begin
                    bus.rd_data[j*WIDTH +: WIDTH] = bus.wb_data[i*WIDTH +: WIDTH];
                    bus.rd_busy[j]                = 1'b0;
                end
            end
`else
            // Reads see stored contents only
`endif
        end
    end

endmodule
